// File: rtl/seq_gen_tx.sv
// Serial frame generator: shifts a captured pattern MSB-first, repeats with idle gaps.
// Optional even-parity bit per frame when SEQ_GEN_TX_PARITY_EN is defined.
module seq_gen_tx #(
   parameter int GAP_CYCLES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] pattern,
   input  logic [2:0] len,
   input  logic [1:0] repeat_n,
   output logic       x,
   output logic       busy,
   output logic       done,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      GAP   = 2'b10,
      PAR   = 2'b11
   } state_t;

   state_t     cur, nxt;
   logic [7:0] pat_q, pat_n;
   logic [2:0] len_q, len_n;
   logic [2:0] cnt_q, cnt_n;
   logic [1:0] frm_q, frm_n;
   logic [3:0] gap_q, gap_n;
   logic       x_n, done_n;
   logic       end_frame;

`ifdef SEQ_GEN_TX_PARITY_EN
   logic parity;

   // Even parity over the len+1 bits that actually go on the wire
   always_comb begin
      parity = 1'b0;
      for (int i = 0; i < 8; i++)
         if (3'(i) <= len_q) parity = parity ^ pat_q[i];
   end
`endif

   always_comb begin
      nxt       = cur;
      pat_n     = pat_q;
      len_n     = len_q;
      cnt_n     = cnt_q;
      frm_n     = frm_q;
      gap_n     = gap_q;
      x_n       = 1'b0;
      done_n    = 1'b0;
      end_frame = 1'b0;

      case (cur)
         IDLE: begin
            if (start) begin
               nxt   = SHIFT;
               pat_n = pattern;
               len_n = len;
               cnt_n = len;
               frm_n = repeat_n;
               x_n   = pattern[len];
            end
         end
         SHIFT: begin
            if (cnt_q != 3'd0) begin
               cnt_n = cnt_q - 3'd1;
               x_n   = pat_q[cnt_q - 3'd1];
            end else begin
`ifdef SEQ_GEN_TX_PARITY_EN
               nxt = PAR;
               x_n = parity;
`else
               end_frame = 1'b1;
`endif
            end
         end
         GAP: begin
            if (gap_q != 4'd0) begin
               gap_n = gap_q - 4'd1;
            end else begin
               nxt   = SHIFT;
               cnt_n = len_q;
               x_n   = pat_q[len_q];
            end
         end
         PAR: end_frame = 1'b1;
         default: nxt = IDLE;
      endcase

      // Frame boundary: restart immediately, go through GAP, or finish
      if (end_frame) begin
         if (frm_q != 2'd0) begin
            frm_n = frm_q - 2'd1;
            if (GAP_CYCLES == 0) begin
               nxt   = SHIFT;
               cnt_n = len_q;
               x_n   = pat_q[len_q];
            end else begin
               nxt   = GAP;
               gap_n = 4'(GAP_CYCLES - 1);
            end
         end else begin
            nxt    = IDLE;
            done_n = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cur   <= IDLE;
         pat_q <= 8'd0;
         len_q <= 3'd0;
         cnt_q <= 3'd0;
         frm_q <= 2'd0;
         gap_q <= 4'd0;
         x     <= 1'b0;
         done  <= 1'b0;
      end else begin
         cur   <= nxt;
         pat_q <= pat_n;
         len_q <= len_n;
         cnt_q <= cnt_n;
         frm_q <= frm_n;
         gap_q <= gap_n;
         x     <= x_n;
         done  <= done_n;
      end
   end

   assign busy  = (cur != IDLE);
   assign state = cur;

endmodule

// File: tb/tb_seq_gen_tx.sv
// Directed bench for seq_gen_tx; inputs driven and outputs sampled on the falling edge.
// Parity-specific expectations are selected by SEQ_GEN_TX_PARITY_EN.
module tb_seq_gen_tx;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] pattern = 8'd0;
   logic [2:0] len = 3'd0;
   logic [1:0] repeat_n = 2'd0;
   logic       x, busy, done;
   logic [1:0] state;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   seq_gen_tx #(.GAP_CYCLES(2)) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .pattern (pattern),
      .len     (len),
      .repeat_n(repeat_n),
      .x       (x),
      .busy    (busy),
      .done    (done),
      .state   (state)
   );

   // Outputs forced low while reset is held, even with start asserted
   task automatic test_reset();
      start    = 1'b1;
      pattern  = 8'b0111_1101;
      len      = 3'd7;
      repeat_n = 2'd0;
      #1;
      checks++;
      if ({x, busy, done, state} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_state: got x/busy/done/state=%b expected 00000", {x, busy, done, state});
      end
      #2 reset = 1'b1;
   endtask

   // Single 8-bit frame, start accepted on the first edge after reset release
   task automatic test_single();
      logic [7:0] e;
      e = 8'b0111_1101;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         if (k == 0) start = 1'b0;
         checks++;
         if ({x, state, busy, done} !== {e[7-k], 2'b01, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_bit%0d: got x,state,busy,done=%b expected %b", k,
                     {x, state, busy, done}, {e[7-k], 2'b01, 1'b1, 1'b0});
         end
      end
`ifdef SEQ_GEN_TX_PARITY_EN
      @(negedge clock);
      checks++;
      if ({x, state} !== 3'b011) begin
         errors++;
         $display("FAIL single_parity: got x,state=%b expected 011", {x, state});
      end
`endif
      @(negedge clock);
      checks++;
      if ({x, state, busy, done} !== 5'b00001) begin
         errors++;
         $display("FAIL single_done: got x,state,busy,done=%b expected 00001", {x, state, busy, done});
      end
      @(negedge clock);
      checks++;
      if ({state, done} !== 3'b000) begin
         errors++;
         $display("FAIL single_done_pulse: got state,done=%b expected 000", {state, done});
      end
   endtask

   // Three frames of 3 bits with two gap cycles between them
   task automatic test_repeat();
      logic [15:0] xe;
      logic [1:0]  se [16];
      int          n;
`ifdef SEQ_GEN_TX_PARITY_EN
      n  = 16;
      xe = 16'b1010_0010_1000_1010;
      se = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1,
             2'd1, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd3};
`else
      n  = 13;
      xe = 16'b1010_0101_0010_1000;
      se = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1,
             2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
`endif
      start    = 1'b1;
      pattern  = 8'b0000_0101;
      len      = 3'd2;
      repeat_n = 2'd2;
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         if (k == 0) start = 1'b0;
         checks++;
         if ({x, state, busy, done} !== {xe[15-k], se[k], 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL repeat_cyc%0d: got x,state,busy,done=%b expected %b", k,
                     {x, state, busy, done}, {xe[15-k], se[k], 1'b1, 1'b0});
         end
      end
      @(negedge clock);
      checks++;
      if ({x, state, busy, done} !== 5'b00001) begin
         errors++;
         $display("FAIL repeat_done: got x,state,busy,done=%b expected 00001", {x, state, busy, done});
      end
   endtask

   // A second start mid-frame must not disturb the stream or add a done
   task automatic test_ignore_start();
      logic [7:0] e;
      e        = 8'b1010_0101;
      start    = 1'b1;
      pattern  = 8'b1010_0101;
      len      = 3'd7;
      repeat_n = 2'd0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         checks++;
         if ({x, state, done} !== {e[7-k], 2'b01, 1'b0}) begin
            errors++;
            $display("FAIL ignore_bit%0d: got x,state,done=%b expected %b", k,
                     {x, state, done}, {e[7-k], 2'b01, 1'b0});
         end
         if (k == 0) start = 1'b0;
         if (k == 2) begin
            start    = 1'b1;
            pattern  = 8'hFF;
            len      = 3'd3;
            repeat_n = 2'd3;
         end
         if (k == 3) start = 1'b0;
      end
`ifdef SEQ_GEN_TX_PARITY_EN
      @(negedge clock);
      checks++;
      if ({x, state} !== 3'b011) begin
         errors++;
         $display("FAIL ignore_parity: got x,state=%b expected 011", {x, state});
      end
`endif
      @(negedge clock);
      checks++;
      if ({x, state, busy, done} !== 5'b00001) begin
         errors++;
         $display("FAIL ignore_done: got x,state,busy,done=%b expected 00001", {x, state, busy, done});
      end
      @(negedge clock);
      checks++;
      if ({x, state, busy, done} !== 5'b00000) begin
         errors++;
         $display("FAIL ignore_single_done: got x,state,busy,done=%b expected 00000", {x, state, busy, done});
      end
   endtask

   // Reset during bit 4 clears outputs at once and never produces done
   task automatic test_reset_mid();
      start    = 1'b1;
      pattern  = 8'hFF;
      len      = 3'd7;
      repeat_n = 2'd0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         if (k == 0) start = 1'b0;
         checks++;
         if ({x, state} !== 3'b101) begin
            errors++;
            $display("FAIL midreset_bit%0d: got x,state=%b expected 101", k, {x, state});
         end
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if ({x, state, busy, done} !== 5'b00000) begin
         errors++;
         $display("FAIL midreset_async: got x,state,busy,done=%b expected 00000", {x, state, busy, done});
      end
      #1 reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         checks++;
         if ({x, state, busy, done} !== 5'b00000) begin
            errors++;
            $display("FAIL midreset_after%0d: got x,state,busy,done=%b expected 00000", k,
                     {x, state, busy, done});
         end
      end
   endtask

   // Start held high with a 1-bit frame restarts in every done cycle
   task automatic test_back_to_back();
      logic [4:0] e [3];
      int         p;
`ifdef SEQ_GEN_TX_PARITY_EN
      p = 3;
      e = '{5'b10110, 5'b11110, 5'b00001};
`else
      p = 2;
      e = '{5'b10110, 5'b00001, 5'b00000};
`endif
      start    = 1'b1;
      pattern  = 8'h01;
      len      = 3'd0;
      repeat_n = 2'd0;
      for (int k = 0; k < 3 * p; k++) begin
         @(negedge clock);
         checks++;
         if ({x, state, busy, done} !== e[k % p]) begin
            errors++;
            $display("FAIL b2b_cyc%0d: got x,state,busy,done=%b expected %b", k,
                     {x, state, busy, done}, e[k % p]);
         end
      end
      start = 1'b0;
      @(negedge clock);
      checks++;
      if ({x, state, busy, done} !== 5'b00000) begin
         errors++;
         $display("FAIL b2b_stop: got x,state,busy,done=%b expected 00000", {x, state, busy, done});
      end
   endtask

`ifdef SEQ_GEN_TX_PARITY_EN
   // Three ones give parity 1, sent from state PAR
   task automatic test_parity();
      logic [2:0] e [4];
      e        = '{3'b101, 3'b101, 3'b101, 3'b111};
      start    = 1'b1;
      pattern  = 8'b0000_0111;
      len      = 3'd2;
      repeat_n = 2'd0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         if (k == 0) start = 1'b0;
         checks++;
         if ({x, state} !== e[k]) begin
            errors++;
            $display("FAIL parity_cyc%0d: got x,state=%b expected %b", k, {x, state}, e[k]);
         end
      end
      @(negedge clock);
      checks++;
      if ({x, state, done} !== 4'b0001) begin
         errors++;
         $display("FAIL parity_done: got x,state,done=%b expected 0001", {x, state, done});
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_repeat();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
`ifdef SEQ_GEN_TX_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
